// File: rtl/script_pkg.sv
// script_pkg: opcodes, executor state codes and instruction field layout.
package script_pkg;
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_SEND   = 3'd3,
        S_WAITT  = 3'd4,
        S_WAITC  = 3'd5,
        S_DONE   = 3'd6,
        S_ERR    = 3'd7
    } state_e;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_ACT   = 3'b001;
    localparam logic [2:0] OP_JMPC  = 3'b010;
    localparam logic [2:0] OP_WAIT  = 3'b011;
    localparam logic [2:0] OP_WAITC = 3'b100;
    localparam logic [2:0] OP_GOTO  = 3'b101;
    localparam logic [2:0] OP_END   = 3'b110;

    typedef struct packed {
        logic [7:0] k;
        logic       rsv;
        logic       p;
        logic [2:0] b;
        logic [2:0] op;
    } instr_t;

    function automatic logic cond_met(input logic [7:0] fb, input instr_t i);
        return fb[i.b] == i.p;
    endfunction
endpackage

// File: rtl/script_executor_tick.sv
// tick_gen: one-cycle pulse every TICK_CYCLES cycles, restartable by clr_i.
module tick_gen #(
    parameter int TICK_CYCLES = 10_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic tick_o
);
    localparam int W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_CYCLES - 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i) cnt_q <= '0;
        else              cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + W'(1);
    end

    assign tick_o = (cnt_q == LAST);
endmodule

// File: rtl/script_executor.sv
// script_executor: ROM-driven command sequencer for auto mode.
// Define SCRIPT_TIMEOUT_EN to add a tick watchdog to WAITC.
module script_executor
    import script_pkg::*;
#(
    parameter int TICK_CYCLES   = 10_000_000,
    parameter int TIMEOUT_TICKS = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mode,
    input  logic        start,
    input  logic [15:0] script,
    input  logic [7:0]  feedback,
    input  logic        cmd_ready,
    output logic [7:0]  pc,
    output logic [7:0]  state_auto,
    output logic [7:0]  cmd,
    output logic        cmd_valid,
    output logic        done,
    output logic        err
);
    // Tick counter must hold both WAIT operands and the watchdog limit.
    localparam int CW = ($clog2(TIMEOUT_TICKS + 1) > 8) ? $clog2(TIMEOUT_TICKS + 1) : 8;

    state_e        state_q, state_d;
    logic [7:0]    pc_q, pc_d, cmd_q, cmd_d, pc_inc;
    instr_t        ir_q, ir_d, in;
    logic [CW-1:0] ticks_q, ticks_d;
    logic          clr, tick;

    assign in     = instr_t'(script);
    assign pc_inc = pc_q + 8'd1;
    assign clr    = (state_q == S_DECODE);

    tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
        .clk(clk), .rst(rst), .clr_i(clr), .tick_o(tick)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        cmd_d   = cmd_q;
        ticks_d = ticks_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: if (start) begin
                pc_d    = '0;
                state_d = S_FETCH;
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                ir_d    = in;
                ticks_d = '0;
                state_d = S_FETCH;
                case (in.op)
                    OP_NOP:   pc_d = pc_inc;
                    OP_ACT:   begin cmd_d = in.k; state_d = S_SEND; end
                    OP_JMPC:  pc_d = cond_met(feedback, in) ? pc_q + in.k : pc_inc;
                    OP_WAIT:  if (in.k == 8'd0) pc_d = pc_inc; else state_d = S_WAITT;
                    OP_WAITC: state_d = S_WAITC;
                    OP_GOTO:  pc_d = in.k;
                    OP_END:   state_d = S_DONE;
                    default:  state_d = S_ERR;
                endcase
            end
            S_SEND: if (cmd_ready) begin
                pc_d    = pc_inc;
                state_d = S_FETCH;
            end
            S_WAITT: if (tick) begin
                ticks_d = ticks_q + CW'(1);
                if (ticks_q == CW'(ir_q.k) - CW'(1)) begin
                    pc_d    = pc_inc;
                    state_d = S_FETCH;
                end
            end
            S_WAITC: begin
                if (cond_met(feedback, ir_q)) begin
                    pc_d    = pc_inc;
                    state_d = S_FETCH;
                end
`ifdef SCRIPT_TIMEOUT_EN
                else if (tick) begin
                    ticks_d = ticks_q + CW'(1);
                    if (ticks_q == CW'(TIMEOUT_TICKS - 1)) state_d = S_ERR;
                end
`endif
            end
        endcase
        // Leaving auto mode aborts everything, even a pending handshake.
        if (!mode) begin
            state_d = S_IDLE;
            pc_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            cmd_q   <= '0;
            ir_q    <= '0;
            ticks_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cmd_q   <= cmd_d;
            ir_q    <= ir_d;
            ticks_q <= ticks_d;
        end
    end

    assign pc         = pc_q;
    assign state_auto = {5'd0, state_q};
    assign cmd        = cmd_q;
    assign cmd_valid  = (state_q == S_SEND);
    assign done       = (state_q == S_DONE);
    assign err        = (state_q == S_ERR);
endmodule

// File: tb/tb_script_executor.sv
// tb_script_executor: program-level interpreter model plus directed scripts.
module tb_script_executor;
    localparam int TICK = 4;
    localparam int TMO  = 3;

    logic        clk = 0, rst, mode, start, cmd_ready;
    logic [15:0] script;
    logic [7:0]  feedback, pc, state_auto, cmd;
    logic        cmd_valid, done, err;

    logic [15:0] rom [256];
    logic [7:0]  exp_cmds [$];
    int n_cmp = 0, n_bad = 0;
    int bp = 0, vcnt = 0;
    int r_cyc, n_wt;
    logic pv = 0, pr = 0;
    logic [7:0] pcmd = 0;

    script_executor #(.TICK_CYCLES(TICK), .TIMEOUT_TICKS(TMO)) dut (
        .clk(clk), .rst(rst), .mode(mode), .start(start), .script(script),
        .feedback(feedback), .cmd_ready(cmd_ready), .pc(pc), .state_auto(state_auto),
        .cmd(cmd), .cmd_valid(cmd_valid), .done(done), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) script <= rom[pc];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    // Consumer: holds cmd_ready low for bp cycles of each command.
    initial begin
        cmd_ready = 0;
        forever begin
            @(posedge clk); #1;
            vcnt = cmd_valid ? vcnt + 1 : 0;
            cmd_ready = cmd_valid && (vcnt > bp);
        end
    end

    always @(negedge clk) if (!rst) begin
        chk("st_hi_zero", int'(state_auto[7:3]), 0);
        chk("flags", {done, err, cmd_valid},
            {state_auto == 8'd6, state_auto == 8'd7, state_auto == 8'd3});
        if (cmd_valid && pv && !pr) chk("cmd_hold", cmd, pcmd);
        if (cmd_valid && cmd_ready) begin
            if (exp_cmds.size() == 0) chk("xfer_extra", 1, 0);
            else chk("xfer_cmd", cmd, exp_cmds.pop_front());
        end
        pv = cmd_valid; pr = cmd_ready; pcmd = cmd;
    end

    // Whole-program interpreter: final pc/state, command list, cycle count.
    function automatic void model_run(input logic [7:0] fb, input int b,
                                      output logic [7:0] mpc, output logic [2:0] mst,
                                      output int mcyc);
        logic [7:0] p; logic [15:0] w; int c;
        p = 0; c = 0; mst = 0;
        for (int s = 0; s < 64; s++) begin
            w = rom[p];
            c += 2;
            case (w[2:0])
                3'd0: p = p + 8'd1;
                3'd1: begin exp_cmds.push_back(w[15:8]); c += b + 1; p = p + 8'd1; end
                3'd2: p = (fb[w[5:3]] == w[6]) ? p + w[15:8] : p + 8'd1;
                3'd3: begin c += int'(w[15:8]) * TICK; p = p + 8'd1; end
                3'd4: if (fb[w[5:3]] == w[6]) begin c += 1; p = p + 8'd1; end
                      else begin mst = 5; mpc = p; mcyc = c; return; end
                3'd5: p = w[15:8];
                3'd6: begin mst = 6; mpc = p; mcyc = c; return; end
                default: begin mst = 7; mpc = p; mcyc = c; return; end
            endcase
        end
        mpc = p; mcyc = c;
    endfunction

    task automatic load(input logic [15:0] w0, input logic [15:0] w1);
        for (int i = 0; i < 256; i++) rom[i] = 16'h0006;
        rom[0] = w0; rom[1] = w1;
    endtask

    task automatic pulse_start;
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
    endtask

    task automatic run(input string nm, input logic [7:0] fb, input int b, input bit poke);
        logic [7:0] mpc; logic [2:0] mst; int mcyc, cyc;
        exp_cmds.delete();
        feedback = fb; bp = b;
        model_run(fb, b, mpc, mst, mcyc);
        pulse_start();
        cyc = 0; n_wt = 0;
        forever begin
            @(negedge clk);
            if (done || err || cyc >= 2000) break;
            cyc++;
            if (state_auto == 8'd4) n_wt++;
            start = poke && (cyc == 5);
        end
        start = 0;
        chk({nm, "_cyc"}, cyc, mcyc);
        chk({nm, "_pc"}, pc, mpc);
        chk({nm, "_state"}, state_auto, mst);
        chk({nm, "_pending"}, exp_cmds.size(), 0);
        r_cyc = cyc;
    endtask

    task automatic wait_state(input logic [7:0] s, input string nm);
        int i;
        for (i = 0; i < 200 && state_auto != s; i++) @(negedge clk);
        chk({nm, "_reach"}, state_auto, s);
    endtask

    initial begin
        int i;
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int i;
        rst = 1; mode = 1; start = 1; feedback = 0;
        load(16'h0006, 16'h0006);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_hold_state", state_auto, 0);
        @(posedge clk); #1 rst = 0; start = 0;
        @(negedge clk);
        chk("rst_state", state_auto, 0);
        chk("rst_pc", pc, 0);
        chk("rst_cmd", cmd, 0);
        chk("rst_valid", cmd_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);

        load(16'h4101, 16'h0006);
        run("act", 8'h00, 5, 0);
        chk("act_cyc_lit", r_cyc, 10);
        chk("act_pc_lit", pc, 1);
        chk("act_state_lit", state_auto, 6);
        chk("act_done_lit", done, 1);

        load(16'h0303, 16'h0006);
        run("wait", 8'h00, 0, 1);
        chk("waitt_len_lit", n_wt, 12);
        chk("wait_pc_lit", pc, 1);

        load(16'h0552, 16'h0006);
        run("jmpc_t", 8'h04, 0, 0);
        chk("jmpc_t_pc_lit", pc, 5);
        run("jmpc_f", 8'h00, 0, 0);
        chk("jmpc_f_pc_lit", pc, 1);

        load(16'hFE05, 16'h0006);
        rom[8'hFE] = 16'h0352;
        run("jmpc_wrap", 8'h04, 0, 0);
        chk("jmpc_wrap_pc_lit", pc, 1);

        load(16'h0007, 16'h0006);
        run("illegal", 8'h00, 0, 0);
        chk("illegal_err_lit", err, 1);
        chk("illegal_pc_lit", pc, 0);
        chk("illegal_state_lit", state_auto, 7);

        load(16'h0054, 16'h0006);
        run("waitc_now", 8'h04, 0, 0);
        chk("waitc_now_cyc_lit", r_cyc, 5);

        load(16'hFF05, 16'h0006);
        rom[8'hFF] = 16'h0000;
        pulse_start();
        for (i = 0; i < 100 && pc != 8'hFF; i++) @(negedge clk);
        chk("wrap_reach_ff", pc, 8'hFF);
        for (i = 0; i < 20 && pc == 8'hFF; i++) @(negedge clk);
        chk("wrap_pc", pc, 0);
        chk("wrap_state", state_auto, 1);
        @(posedge clk); #1 mode = 0;
        @(negedge clk); @(negedge clk);
        chk("abort_loop_state", state_auto, 0);
        chk("abort_loop_pc", pc, 0);
        @(posedge clk); #1 mode = 1;

        load(16'h0054, 16'h0006);
        feedback = 8'h00;
        pulse_start();
        wait_state(8'd5, "waitc_abort");
        repeat (2) @(negedge clk);
        chk("waitc_stays", state_auto, 5);
        @(posedge clk); #1 mode = 0;
        @(negedge clk); @(negedge clk);
        chk("waitc_abort_state", state_auto, 0);
        chk("waitc_abort_pc", pc, 0);
        chk("waitc_abort_valid", cmd_valid, 0);
        @(posedge clk); #1 mode = 1;

`ifdef SCRIPT_TIMEOUT_EN
        pulse_start();
        wait_state(8'd5, "tmo");
        i = 0;
        while (state_auto == 8'd5 && i < 200) begin i++; @(negedge clk); end
        chk("tmo_len", i, 12);
        chk("tmo_state", state_auto, 7);
        chk("tmo_pc", pc, 0);
`endif

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
